// File: rtl/g28_pkg.sv
// Shared types and constants for the G28 homing sequencer.
package g28_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam int unsigned AX_X  = 0;
    localparam int unsigned AX_Y  = 1;
    localparam int unsigned AX_Z  = 2;
    localparam int unsigned CNT_W = 32;

    localparam logic [2:0] ALL_AXES = 3'b111;

    // Down-count that sticks at zero instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? v : v - CNT_W'(1);
    endfunction

endpackage

// File: rtl/endstop_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw endstop.
module endstop_debounce
    import g28_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_db
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    // Output flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_db    <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/g28_homing_sequencer.sv
// G28 command sequencer: arms the homing drive stage, waits for motion to stop,
// confirms the selected endstops stay settled, and reports done or fault.
module g28_homing_sequencer
    import g28_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50_000,
    parameter int unsigned SETTLE_CYCLES   = 250_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_axes,
    input  logic       abort,
    input  logic       xmin_raw,
    input  logic       ymin_raw,
    input  logic       zmin_raw,
    output logic       xmin,
    output logic       ymin,
    output logic       zmin,
    output logic       homex,
    output logic       homey,
    output logic       homez,
    output logic       start_driving,
    input  logic       steppers_driving,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] homed
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_mask;
    logic [2:0]       w_mask_nxt;
    logic [2:0]       r_home;
    logic [2:0]       w_home_nxt;
    logic [2:0]       r_homed;
    logic [2:0]       w_homed_nxt;
    logic             r_start;
    logic             w_start_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_fault;
    logic             w_fault_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_cmd_ready;
    logic             w_cmd_ready_nxt;
    logic [CNT_W-1:0] r_timeout;
    logic [CNT_W-1:0] w_timeout_nxt;
    logic [CNT_W-1:0] r_settle;
    logic [CNT_W-1:0] w_settle_nxt;
    logic [CNT_W-1:0] r_prime_cnt;
    logic             r_primed;
    logic             w_primed_nxt;
    logic [2:0]       w_min;
    logic             w_sel_ok;
    logic             w_accept;
    logic             w_timeout_hit;

    endstop_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_x (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (xmin_raw),
        .o_db  (w_min[AX_X])
    );

    endstop_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_y (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (ymin_raw),
        .o_db  (w_min[AX_Y])
    );

    endstop_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_z (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (zmin_raw),
        .o_db  (w_min[AX_Z])
    );

    // Debouncers need sync depth plus a full stable window before their outputs mean anything.
    assign w_primed_nxt = r_primed | (r_prime_cnt == CNT_W'(DEBOUNCE_CYCLES + 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prime_cnt <= '0;
            r_primed    <= 1'b0;
        end else begin
            r_primed <= w_primed_nxt;
            if (!r_primed) begin
                r_prime_cnt <= r_prime_cnt + CNT_W'(1);
            end
        end
    end

    assign w_sel_ok      = &(w_min | ~r_mask);
    assign w_accept      = cmd_valid & r_cmd_ready & ~abort;
    assign w_timeout_hit = (r_timeout <= CNT_W'(1));

    always_comb begin
        w_state_nxt     = r_state;
        w_mask_nxt      = r_mask;
        w_home_nxt      = r_home;
        w_homed_nxt     = r_homed;
        w_start_nxt     = r_start;
        w_done_nxt      = 1'b0;
        w_fault_nxt     = r_fault;
        w_timeout_nxt   = r_timeout;
        w_settle_nxt    = r_settle;
        w_busy_nxt      = 1'b0;
        w_cmd_ready_nxt = 1'b0;

        case (r_state)
            IDLE, FAULT: begin
                if (w_accept) begin
                    w_mask_nxt  = (cmd_axes == 3'b000) ? ALL_AXES : cmd_axes;
                    w_homed_nxt = r_homed & ~w_mask_nxt;
                    w_fault_nxt = 1'b0;
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                w_home_nxt    = r_mask;
                w_start_nxt   = 1'b1;
                w_timeout_nxt = CNT_W'(TIMEOUT_CYCLES);
                w_state_nxt   = RUN;
            end
            RUN: begin
                w_timeout_nxt = sat_dec(r_timeout);
                if (w_timeout_hit) begin
                    w_state_nxt = FAULT;
                    w_fault_nxt = 1'b1;
                    w_start_nxt = 1'b0;
                    w_home_nxt  = 3'b000;
                end else if (!steppers_driving) begin
                    w_state_nxt  = SETTLE;
                    w_settle_nxt = CNT_W'(SETTLE_CYCLES);
                end
            end
            SETTLE: begin
                w_timeout_nxt = sat_dec(r_timeout);
                if (w_timeout_hit) begin
                    w_state_nxt = FAULT;
                    w_fault_nxt = 1'b1;
                    w_start_nxt = 1'b0;
                    w_home_nxt  = 3'b000;
                end else if (!w_sel_ok) begin
                    w_state_nxt = RUN;
                end else if (r_settle <= CNT_W'(1)) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_homed_nxt = r_homed | r_mask;
                    w_start_nxt = 1'b0;
                    w_home_nxt  = 3'b000;
                end else begin
                    w_settle_nxt = sat_dec(r_settle);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Abort overrides every other outcome, including a completion in the same cycle.
        if (abort) begin
            w_start_nxt = 1'b0;
            w_home_nxt  = 3'b000;
            if (r_state inside {ARM, RUN, SETTLE}) begin
                w_state_nxt = FAULT;
                w_fault_nxt = 1'b1;
                w_done_nxt  = 1'b0;
                w_homed_nxt = r_homed;
            end
        end

        w_busy_nxt      = w_state_nxt inside {ARM, RUN, SETTLE};
        w_cmd_ready_nxt = w_primed_nxt && !abort &&
                          ((w_state_nxt == IDLE) || (w_state_nxt == FAULT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mask      <= 3'b000;
            r_home      <= 3'b000;
            r_homed     <= 3'b000;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_timeout   <= '0;
            r_settle    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_home      <= w_home_nxt;
            r_homed     <= w_homed_nxt;
            r_start     <= w_start_nxt;
            r_done      <= w_done_nxt;
            r_fault     <= w_fault_nxt;
            r_busy      <= w_busy_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_timeout   <= w_timeout_nxt;
            r_settle    <= w_settle_nxt;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign xmin          = w_min[AX_X];
    assign ymin          = w_min[AX_Y];
    assign zmin          = w_min[AX_Z];
    assign homex         = r_home[AX_X];
    assign homey         = r_home[AX_Y];
    assign homez         = r_home[AX_Z];
    assign start_driving = r_start;
    assign busy          = r_busy;
    assign done          = r_done;
    assign fault         = r_fault;
    assign homed         = r_homed;

endmodule
